// File: rtl/pinmux_if.sv
// ----------------------------------------------------------------------------
// pinmux_if -- TL-UL style register port bundle for the pinmux.
//
// Only the channel fields that the pinmux uses are carried.
//   a_*      : request channel, driven by the host.
//   a_ready  : request channel ready, driven by the device.
//   d_*      : response channel, driven by the device.
//   d_ready  : response channel ready, driven by the host.
// Modports: master (host side), slave (device side).
// ----------------------------------------------------------------------------
interface pinmux_if;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_ready;

  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic [31:0] d_data;
  logic        d_error;
  logic        d_ready;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    output d_ready,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_data, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    input  d_ready,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_data, d_error
  );
endinterface

// File: rtl/pinmux.sv
// ----------------------------------------------------------------------------
// pinmux -- register-configured pin multiplexer.
//
// Every board pin has a 5-bit output select (OSEL, 0x000 + 4*pin) choosing
// which peripheral output drives it. Every peripheral input has a 5-bit input
// select (ISEL, 0x100 + 4*input) choosing which pin feeds it; 0 or an out of
// range value falls back to the input's idle default.
//
// Output source indices : 0 none, 1-2 uart_tx, 3-4 i2c_scl, 5-6 i2c_sda,
//                         7-8 spi_sck, 9-10 spi_tx, 11-18 gpio, 19-31 none.
// Peripheral input index: 0-1 uart_rx, 2-3 i2c_scl, 4-5 i2c_sda, 6-7 spi_rx,
//                         8-15 gpio.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   tl                    register port (pinmux_if.slave)
//   uart_tx_i/uart_rx_o   UART lines from/to the UART peripherals
//   i2c_scl_i/_en_i, i2c_sda_i/_en_i, i2c_scl_o, i2c_sda_o
//   spi_sck_i, spi_tx_i, spi_rx_o
//   gpio_ios_i, gpio_ios_en_i, gpio_ios_o
//   from_pins_i, from_pins_en_o, to_pins_o, to_pins_en_o   board pins
//
// Build option: PINMUX_INPUT_SYNC_EN -- when defined, from_pins_i passes
// through a 2-flop synchronizer (reset to 1) before input muxing.
// ----------------------------------------------------------------------------
module pinmux #(
  parameter int NumUart   = 2,
  parameter int NumI2c    = 2,
  parameter int NumSpi    = 2,
  parameter int GpioWidth = 8,
  parameter int NumPins   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pinmux_if.slave              tl,
  input  logic [NumUart-1:0]   uart_tx_i,
  output logic [NumUart-1:0]   uart_rx_o,
  input  logic [NumI2c-1:0]    i2c_scl_i,
  input  logic [NumI2c-1:0]    i2c_scl_en_i,
  input  logic [NumI2c-1:0]    i2c_sda_i,
  input  logic [NumI2c-1:0]    i2c_sda_en_i,
  output logic [NumI2c-1:0]    i2c_scl_o,
  output logic [NumI2c-1:0]    i2c_sda_o,
  input  logic [NumSpi-1:0]    spi_sck_i,
  input  logic [NumSpi-1:0]    spi_tx_i,
  output logic [NumSpi-1:0]    spi_rx_o,
  input  logic [GpioWidth-1:0] gpio_ios_i,
  input  logic [GpioWidth-1:0] gpio_ios_en_i,
  output logic [GpioWidth-1:0] gpio_ios_o,
  input  logic [NumPins-1:0]   from_pins_i,
  output logic [NumPins-1:0]   from_pins_en_o,
  output logic [NumPins-1:0]   to_pins_o,
  output logic [NumPins-1:0]   to_pins_en_o
);

  // Output source index layout
  localparam int OutUart  = 1;
  localparam int OutScl   = OutUart + NumUart;
  localparam int OutSda   = OutScl + NumI2c;
  localparam int OutSck   = OutSda + NumI2c;
  localparam int OutSpiTx = OutSck + NumSpi;
  localparam int OutGpio  = OutSpiTx + NumSpi;

  // Peripheral input index layout
  localparam int InUart = 0;
  localparam int InScl  = InUart + NumUart;
  localparam int InSda  = InScl + NumI2c;
  localparam int InSpi  = InSda + NumI2c;
  localparam int InGpio = InSpi + NumSpi;
  localparam int NumIn  = InGpio + GpioWidth;

  localparam int PinIdxW = $clog2(NumPins);

  localparam logic [2:0] OpPutFull    = 3'd0;
  localparam logic [2:0] OpPutPartial = 3'd1;
  localparam logic [2:0] OpGet        = 3'd4;
  localparam logic [2:0] OpAccessAck  = 3'd0;
  localparam logic [2:0] OpAckData    = 3'd1;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [NumPins-1:0][4:0] osel_q, osel_d;
  logic [NumIn-1:0][4:0]   isel_q, isel_d;

  logic        d_valid_q, d_valid_d;
  logic [2:0]  d_opcode_q, d_opcode_d;
  logic [1:0]  d_size_q, d_size_d;
  logic [7:0]  d_source_q, d_source_d;
  logic [31:0] d_data_q, d_data_d;
  logic        d_error_q, d_error_d;

  // --------------------------------------------------------------------------
  // Register port
  // --------------------------------------------------------------------------
  logic       accept;
  logic [3:0] reg_idx;
  logic       hit_osel, hit_isel;
  logic [4:0] rd_val;

  assign tl.a_ready = ~d_valid_q;
  assign accept     = tl.a_valid & ~d_valid_q;
  assign reg_idx    = tl.a_address[5:2];

  // Both register banks are 16 words; anything else in the space is unmapped,
  // including non word-aligned addresses.
  assign hit_osel = (tl.a_address[31:8] == 24'd0) && (tl.a_address[7:6] == 2'd0)
                    && (tl.a_address[1:0] == 2'd0);
  assign hit_isel = (tl.a_address[31:9] == 23'd0) && tl.a_address[8]
                    && (tl.a_address[7:6] == 2'd0) && (tl.a_address[1:0] == 2'd0);

  assign rd_val = hit_isel ? isel_q[reg_idx] : osel_q[reg_idx];

  // Only the low byte lane and the low five data bits reach a register.
  logic unused_tl;
  assign unused_tl = ^{tl.a_data[31:5], tl.a_mask[3:1]};

  always_comb begin
    osel_d     = osel_q;
    isel_d     = isel_q;
    d_valid_d  = d_valid_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
    d_error_d  = d_error_q;

    if (accept) begin
      d_valid_d  = 1'b1;
      d_size_d   = tl.a_size;
      d_source_d = tl.a_source;
      d_data_d   = 32'd0;
      d_error_d  = 1'b0;
      case (tl.a_opcode)
        OpGet: begin
          d_opcode_d = OpAckData;
          if (hit_osel || hit_isel) begin
            d_data_d = {27'd0, rd_val};
          end else begin
            d_error_d = 1'b1;
          end
        end
        OpPutFull, OpPutPartial: begin
          d_opcode_d = OpAccessAck;
          if (!(hit_osel || hit_isel)) begin
            d_error_d = 1'b1;
          end else if (tl.a_mask[0]) begin
            if (hit_isel) isel_d[reg_idx] = tl.a_data[4:0];
            else          osel_d[reg_idx] = tl.a_data[4:0];
          end
        end
        default: begin
          d_opcode_d = OpAccessAck;
          d_error_d  = 1'b1;
        end
      endcase
    end else if (d_valid_q && tl.d_ready) begin
      d_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      osel_q     <= '0;
      isel_q     <= '0;
      d_valid_q  <= 1'b0;
      d_opcode_q <= 3'd0;
      d_size_q   <= 2'd0;
      d_source_q <= 8'd0;
      d_data_q   <= 32'd0;
      d_error_q  <= 1'b0;
    end else begin
      osel_q     <= osel_d;
      isel_q     <= isel_d;
      d_valid_q  <= d_valid_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_data_q   <= d_data_d;
      d_error_q  <= d_error_d;
    end
  end

  assign tl.d_valid  = d_valid_q;
  assign tl.d_opcode = d_opcode_q;
  assign tl.d_size   = d_size_q;
  assign tl.d_source = d_source_q;
  assign tl.d_data   = d_data_q;
  assign tl.d_error  = d_error_q;

  // --------------------------------------------------------------------------
  // Output mux: flatten every source into a 32-entry table indexed by OSEL.
  // Unpopulated entries stay 0 / not driven.
  // --------------------------------------------------------------------------
  logic [31:0] src_val, src_en;

  always_comb begin
    src_val = '0;
    src_en  = '0;
    for (int u = 0; u < NumUart; u++) begin
      src_val[OutUart + u] = uart_tx_i[u];
      src_en[OutUart + u]  = 1'b1;
    end
    for (int c = 0; c < NumI2c; c++) begin
      src_val[OutScl + c] = i2c_scl_i[c];
      src_en[OutScl + c]  = i2c_scl_en_i[c];
      src_val[OutSda + c] = i2c_sda_i[c];
      src_en[OutSda + c]  = i2c_sda_en_i[c];
    end
    for (int s = 0; s < NumSpi; s++) begin
      src_val[OutSck + s]   = spi_sck_i[s];
      src_en[OutSck + s]    = 1'b1;
      src_val[OutSpiTx + s] = spi_tx_i[s];
      src_en[OutSpiTx + s]  = 1'b1;
    end
    for (int g = 0; g < GpioWidth; g++) begin
      src_val[OutGpio + g] = gpio_ios_i[g];
      src_en[OutGpio + g]  = gpio_ios_en_i[g];
    end
  end

  always_comb begin
    to_pins_o    = '0;
    to_pins_en_o = '0;
    for (int p = 0; p < NumPins; p++) begin
      to_pins_o[p]    = src_val[osel_q[p]];
      to_pins_en_o[p] = src_en[osel_q[p]];
    end
  end

  // --------------------------------------------------------------------------
  // Pin input path
  // --------------------------------------------------------------------------
  logic [NumPins-1:0] pin_in;

`ifdef PINMUX_INPUT_SYNC_EN
  // Idle-high reset value keeps pulled-up lines (UART, I2C) quiet while the
  // synchronizer fills after reset.
  logic [NumPins-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= from_pins_i;
      sync2_q <= sync1_q;
    end
  end

  assign pin_in = sync2_q;
`else
  assign pin_in = from_pins_i;
`endif

  // --------------------------------------------------------------------------
  // Input mux: ISEL value k in 1..NumPins picks pin k-1, anything else the
  // idle default (pulled-up buses read 1, the rest 0).
  // --------------------------------------------------------------------------
  function automatic logic sel_valid(input logic [4:0] sel);
    return (sel != 5'd0) && (int'(sel) <= NumPins);
  endfunction

  function automatic logic [PinIdxW-1:0] sel_pin(input logic [4:0] sel);
    return PinIdxW'(sel - 5'd1);
  endfunction

  logic [NumIn-1:0] in_dflt;
  logic [NumIn-1:0] periph_in;

  always_comb begin
    in_dflt = '0;
    for (int i = InUart; i < InSpi; i++) begin
      in_dflt[i] = 1'b1;
    end
  end

  always_comb begin
    periph_in      = in_dflt;
    from_pins_en_o = '0;
    for (int i = 0; i < NumIn; i++) begin
      if (sel_valid(isel_q[i])) begin
        periph_in[i]                       = pin_in[sel_pin(isel_q[i])];
        from_pins_en_o[sel_pin(isel_q[i])] = 1'b1;
      end
    end
  end

  assign uart_rx_o  = periph_in[InUart +: NumUart];
  assign i2c_scl_o  = periph_in[InScl +: NumI2c];
  assign i2c_sda_o  = periph_in[InSda +: NumI2c];
  assign spi_rx_o   = periph_in[InSpi +: NumSpi];
  assign gpio_ios_o = periph_in[InGpio +: GpioWidth];

endmodule

// File: tb/tb_pinmux.sv
module tb_pinmux;

`ifdef PINMUX_INPUT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  logic [1:0]  uart_tx_i = '0;
  logic [1:0]  uart_rx_o;
  logic [1:0]  i2c_scl_i = '0, i2c_scl_en_i = '0, i2c_sda_i = '0, i2c_sda_en_i = '0;
  logic [1:0]  i2c_scl_o, i2c_sda_o;
  logic [1:0]  spi_sck_i = '0, spi_tx_i = '0;
  logic [1:0]  spi_rx_o;
  logic [7:0]  gpio_ios_i = '0, gpio_ios_en_i = '0;
  logic [7:0]  gpio_ios_o;
  logic [15:0] from_pins_i = 16'hFFFF;
  logic [15:0] from_pins_en_o, to_pins_o, to_pins_en_o;

  int checks   = 0;
  int failures = 0;
  logic [7:0] tag = 8'h10;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic        err;
    logic [7:0]  src;
    logic [1:0]  size;
  } rsp_t;
  rsp_t sb_q[$];

  pinmux_if tl();

  pinmux dut (
    .clk_i(clk_i), .rst_i(rst_i), .tl(tl),
    .uart_tx_i(uart_tx_i), .uart_rx_o(uart_rx_o),
    .i2c_scl_i(i2c_scl_i), .i2c_scl_en_i(i2c_scl_en_i),
    .i2c_sda_i(i2c_sda_i), .i2c_sda_en_i(i2c_sda_en_i),
    .i2c_scl_o(i2c_scl_o), .i2c_sda_o(i2c_sda_o),
    .spi_sck_i(spi_sck_i), .spi_tx_i(spi_tx_i), .spi_rx_o(spi_rx_o),
    .gpio_ios_i(gpio_ios_i), .gpio_ios_en_i(gpio_ios_en_i), .gpio_ios_o(gpio_ios_o),
    .from_pins_i(from_pins_i), .from_pins_en_o(from_pins_en_o),
    .to_pins_o(to_pins_o), .to_pins_en_o(to_pins_en_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One register-port transaction. The expected response is queued when the
  // request is driven and popped when the DUT raises d_valid. 'hold' keeps
  // d_ready low for that many cycles while the response must stay put.
  task automatic tl_xfer(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] mask,
                         input logic [2:0] exp_op, input logic [31:0] exp_data,
                         input logic exp_err, input int hold);
    rsp_t e, got;
    int n;
    e.op = exp_op; e.data = exp_data; e.err = exp_err; e.src = tag; e.size = 2'd2;
    @(negedge clk_i);
    tl.a_valid = 1'b1; tl.a_opcode = op; tl.a_address = addr; tl.a_data = data;
    tl.a_mask = mask; tl.a_source = tag; tl.a_size = 2'd2;
    sb_q.push_back(e);
    @(negedge clk_i);
    tl.a_valid = 1'b0;
    n = 0;
    while (tl.d_valid !== 1'b1 && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (tl.d_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_timeout addr=%h: d_valid=%b required 1", addr, tl.d_valid);
      void'(sb_q.pop_front());
    end else begin
      for (int h = 0; h < hold; h++) begin
        checks++;
        if (tl.d_valid !== 1'b1 || tl.a_ready !== 1'b0) begin
          failures++;
          $display("FAIL rsp_hold cycle=%0d: d_valid=%b a_ready=%b required 1/0", h, tl.d_valid, tl.a_ready);
        end
        @(negedge clk_i);
      end
      got.op = tl.d_opcode; got.data = tl.d_data; got.err = tl.d_error;
      got.src = tl.d_source; got.size = tl.d_size;
      e = sb_q.pop_front();
      checks++;
      if (got.op !== e.op || got.data !== e.data || got.err !== e.err ||
          got.src !== e.src || got.size !== e.size) begin
        failures++;
        $display("FAIL rsp addr=%h: op=%0d data=%h err=%b src=%h size=%0d required op=%0d data=%h err=%b src=%h size=%0d",
                 addr, got.op, got.data, got.err, got.src, got.size, e.op, e.data, e.err, e.src, e.size);
      end
      tl.d_ready = 1'b1;
      @(negedge clk_i);
      tl.d_ready = 1'b0;
      checks++;
      if (tl.d_valid !== 1'b0 || tl.a_ready !== 1'b1) begin
        failures++;
        $display("FAIL rsp_release: d_valid=%b a_ready=%b required 0/1", tl.d_valid, tl.a_ready);
      end
    end
    tag = tag + 8'd1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    tl_xfer(3'd0, addr, data, 4'hF, 3'd0, 32'd0, 1'b0, 0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    tl_xfer(3'd4, addr, 32'd0, 4'hF, 3'd1, exp, 1'b0, 0);
  endtask

  task automatic settle();
    repeat (SYNC_LAT) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    tl.a_valid = 1'b0; tl.a_opcode = 3'd0; tl.a_address = '0; tl.a_data = '0;
    tl.a_mask = 4'hF; tl.a_source = '0; tl.a_size = 2'd2; tl.d_ready = 1'b0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (to_pins_en_o !== 16'h0000 || to_pins_o !== 16'h0000 || from_pins_en_o !== 16'h0000) begin
      failures++;
      $display("FAIL reset_pins: en=%h val=%h in_en=%h required 0/0/0", to_pins_en_o, to_pins_o, from_pins_en_o);
    end
    checks++;
    if (uart_rx_o !== 2'b11 || i2c_scl_o !== 2'b11 || i2c_sda_o !== 2'b11 ||
        spi_rx_o !== 2'b00 || gpio_ios_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_defaults: uart=%b scl=%b sda=%b spi=%b gpio=%h required 11/11/11/00/00",
               uart_rx_o, i2c_scl_o, i2c_sda_o, spi_rx_o, gpio_ios_o);
    end
    checks++;
    if (tl.d_valid !== 1'b0 || tl.a_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_tl: d_valid=%b a_ready=%b required 0/1", tl.d_valid, tl.a_ready);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_uart_out();
    wr(32'h00C, 32'd1);
    @(negedge clk_i); uart_tx_i[0] = 1'b0; #1;
    checks++;
    if (to_pins_o[3] !== 1'b0 || to_pins_en_o !== 16'h0008) begin
      failures++;
      $display("FAIL uart_out_lo: val=%b en=%h required 0/0008", to_pins_o[3], to_pins_en_o);
    end
    @(negedge clk_i); uart_tx_i[0] = 1'b1; #1;
    checks++;
    if (to_pins_o[3] !== 1'b1 || to_pins_en_o !== 16'h0008) begin
      failures++;
      $display("FAIL uart_out_hi: val=%b en=%h required 1/0008", to_pins_o[3], to_pins_en_o);
    end
    rd(32'h00C, 32'd1);
  endtask

  task automatic test_i2c_out();
    wr(32'h014, 32'd3);
    @(negedge clk_i); i2c_scl_i[0] = 1'b0; i2c_scl_en_i[0] = 1'b0; #1;
    checks++;
    if (to_pins_en_o[5] !== 1'b0 || to_pins_o[5] !== 1'b0) begin
      failures++;
      $display("FAIL i2c_en_off: en=%b val=%b required 0/0", to_pins_en_o[5], to_pins_o[5]);
    end
    @(negedge clk_i); i2c_scl_en_i[0] = 1'b1; #1;
    checks++;
    if (to_pins_en_o[5] !== 1'b1 || to_pins_o[5] !== 1'b0) begin
      failures++;
      $display("FAIL i2c_en_on: en=%b val=%b required 1/0", to_pins_en_o[5], to_pins_o[5]);
    end
    // sda[1] (index 6) on pin 4, gated by its own enable
    wr(32'h010, 32'd6);
    @(negedge clk_i); i2c_sda_i[1] = 1'b1; i2c_sda_en_i = 2'b10; #1;
    checks++;
    if (to_pins_en_o[4] !== 1'b1 || to_pins_o[4] !== 1'b1) begin
      failures++;
      $display("FAIL i2c_sda1: en=%b val=%b required 1/1", to_pins_en_o[4], to_pins_o[4]);
    end
  endtask

  task automatic test_gpio_spi_out();
    wr(32'h018, 32'd13);   // pin 6 <- gpio[2]
    wr(32'h01C, 32'd10);   // pin 7 <- spi_tx[1]
    wr(32'h020, 32'd19);   // pin 8 <- first unused index
    @(negedge clk_i);
    gpio_ios_i = 8'h04; gpio_ios_en_i = 8'h00; spi_tx_i = 2'b10; #1;
    checks++;
    if (to_pins_o[8:6] !== 3'b011 || to_pins_en_o[8:6] !== 3'b010) begin
      failures++;
      $display("FAIL gpio_spi_a: val=%b en=%b required 011/010", to_pins_o[8:6], to_pins_en_o[8:6]);
    end
    @(negedge clk_i); gpio_ios_en_i = 8'h04; spi_tx_i = 2'b00; #1;
    checks++;
    if (to_pins_o[8:6] !== 3'b001 || to_pins_en_o[8:6] !== 3'b011) begin
      failures++;
      $display("FAIL gpio_spi_b: val=%b en=%b required 001/011", to_pins_o[8:6], to_pins_en_o[8:6]);
    end
  endtask

  task automatic test_input();
    @(negedge clk_i); from_pins_i = 16'hFF7D;   // pin 7 and pin 1 low
    wr(32'h100, 32'd8);                         // uart_rx[0] <- pin 7
    settle();
    checks++;
    if (uart_rx_o !== 2'b10 || from_pins_en_o !== 16'h0080) begin
      failures++;
      $display("FAIL in_uart_sel: uart=%b en=%h required 10/0080", uart_rx_o, from_pins_en_o);
    end
    @(negedge clk_i); from_pins_i[7] = 1'b1;
    settle();
    checks++;
    if (uart_rx_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL in_uart_follow: uart0=%b required 1", uart_rx_o[0]);
    end
    @(negedge clk_i); from_pins_i[7] = 1'b0;
    wr(32'h100, 32'd0);
    settle();
    checks++;
    if (uart_rx_o[0] !== 1'b1 || from_pins_en_o !== 16'h0000) begin
      failures++;
      $display("FAIL in_uart_dflt: uart0=%b en=%h required 1/0000", uart_rx_o[0], from_pins_en_o);
    end
    wr(32'h118, 32'd1);    // spi_rx[0] <- pin 0
    wr(32'h110, 32'd2);    // i2c_sda[0] <- pin 1 (low)
    wr(32'h120, 32'd17);   // gpio[0] out of range -> default
    wr(32'h13C, 32'd16);   // gpio[7] <- pin 15
    settle();
    checks++;
    if (spi_rx_o !== 2'b01 || i2c_sda_o !== 2'b10 || gpio_ios_o !== 8'h80) begin
      failures++;
      $display("FAIL in_multi: spi=%b sda=%b gpio=%h required 01/10/80", spi_rx_o, i2c_sda_o, gpio_ios_o);
    end
    checks++;
    if (from_pins_en_o !== 16'h8003) begin
      failures++;
      $display("FAIL in_en_multi: en=%h required 8003", from_pins_en_o);
    end
    rd(32'h13C, 32'd16);
    rd(32'h120, 32'd17);
  endtask

  task automatic test_errors();
    tl_xfer(3'd4, 32'h200, 32'd0, 4'hF, 3'd1, 32'd0, 1'b1, 3);
    tl_xfer(3'd0, 32'h040, 32'd5, 4'hF, 3'd0, 32'd0, 1'b1, 0);
    tl_xfer(3'd2, 32'h00C, 32'd5, 4'hF, 3'd0, 32'd0, 1'b1, 0);
    rd(32'h00C, 32'd1);
    rd(32'h000, 32'd0);
  endtask

  task automatic test_mask();
    wr(32'h000, 32'd20);
    #1;
    checks++;
    if (to_pins_en_o[0] !== 1'b0 || to_pins_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL osel_invalid: en=%b val=%b required 0/0", to_pins_en_o[0], to_pins_o[0]);
    end
    tl_xfer(3'd0, 32'h000, 32'd1, 4'b1110, 3'd0, 32'd0, 1'b0, 0);
    rd(32'h000, 32'd20);
    tl_xfer(3'd1, 32'h000, 32'd7, 4'b0001, 3'd0, 32'd0, 1'b0, 0);   // pin 0 <- spi_sck[0]
    @(negedge clk_i); spi_sck_i[0] = 1'b1; #1;
    checks++;
    if (to_pins_en_o[0] !== 1'b1 || to_pins_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL partial_write: en=%b val=%b required 1/1", to_pins_en_o[0], to_pins_o[0]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i); gpio_ios_i = 8'h05; gpio_ios_en_i = 8'h03;
    for (int i = 0; i < 4; i++) begin
      wr(32'h020 + 32'(4 * i), 32'(11 + i));   // pins 8..11 <- gpio[0..3]
    end
    #1;
    checks++;
    if (to_pins_o[11:8] !== 4'b0101 || to_pins_en_o[11:8] !== 4'b0011) begin
      failures++;
      $display("FAIL b2b_pins: val=%b en=%b required 0101/0011", to_pins_o[11:8], to_pins_en_o[11:8]);
    end
    for (int i = 0; i < 4; i++) begin
      rd(32'h020 + 32'(4 * i), 32'(11 + i));
    end
  endtask

  task automatic test_reset_pending();
    @(negedge clk_i);
    tl.a_valid = 1'b1; tl.a_opcode = 3'd4; tl.a_address = 32'h00C; tl.a_source = tag;
    @(negedge clk_i);
    tl.a_valid = 1'b0;
    checks++;
    if (tl.d_valid !== 1'b1) begin
      failures++;
      $display("FAIL pend_rsp: d_valid=%b required 1", tl.d_valid);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (tl.d_valid !== 1'b0 || to_pins_en_o !== 16'h0000 || from_pins_en_o !== 16'h0000) begin
      failures++;
      $display("FAIL async_reset: d_valid=%b en=%h in_en=%h required 0/0000/0000",
               tl.d_valid, to_pins_en_o, from_pins_en_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    tag = tag + 8'd1;
    rd(32'h00C, 32'd0);
  endtask

  initial begin
    test_reset();
    test_uart_out();
    test_i2c_out();
    test_gpio_spi_out();
    test_input();
    test_errors();
    test_mask();
    test_back_to_back();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
